// File: rtl/scope_capture_ng.sv
// scope_capture_ng: decimating trace capture into a ping-pong buffer with an
// optional level trigger, and a scrolling Y-coordinate readout for the VGA
// pixel pipeline. Banks swap only on a Vsyn falling edge so the display never tears.
module scope_capture_ng #(
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 64,
    parameter int DECIM           = 31,
    parameter int Y_CENTER        = 239,
    parameter int Y_SCALE         = 120,
    parameter int PIX_STEP        = 1,
    parameter int SCROLL_STEP     = 1,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                     CLOCK_50,
    input  logic                     KEY,
    input  logic                     pix_en,
    input  logic                     Vsyn,
    input  logic                     blank_n,
    input  logic signed [DATA_W-1:0] ifft_Iout,
    input  logic signed [DATA_W-1:0] ifft_Qout,
    input  logic [1:0]               ch_sel,
    input  logic [1:0]               trig_mode,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     run,
    output logic [9:0]               Val_CY,
    output logic [1:0]               state,
    output logic                     swap_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DATA_W+1:0] MAG_MAX = (DATA_W+2)'((1 << (DATA_W-1)) - 1);

    // |I|+|Q| with one bit of headroom per operand, saturated to the positive full scale.
    function automatic logic signed [DATA_W-1:0] sat_mag(input logic signed [DATA_W-1:0] i,
                                                         input logic signed [DATA_W-1:0] q);
        logic signed [DATA_W:0] ei;
        logic signed [DATA_W:0] eq;
        logic [DATA_W:0]        ai;
        logic [DATA_W:0]        aq;
        logic [DATA_W+1:0]      sum;
        ei  = {i[DATA_W-1], i};
        eq  = {q[DATA_W-1], q};
        ai  = ei[DATA_W] ? $unsigned(-ei) : $unsigned(ei);
        aq  = eq[DATA_W] ? $unsigned(-eq) : $unsigned(eq);
        sum = {1'b0, ai} + {1'b0, aq};
        if (sum > MAG_MAX)
            return $signed(MAG_MAX[DATA_W-1:0]);
        return $signed(sum[DATA_W-1:0]);
    endfunction

    // Screen Y for a sample: scale, arithmetic shift back to pixels, clamp to the visible rows.
    function automatic logic [9:0] y_of(input logic signed [DATA_W-1:0] s);
        logic signed [31:0] prod;
        logic signed [31:0] y;
        prod = $signed(32'(s)) * $signed(Y_SCALE);
        y    = Y_CENTER - (prod >>> (DATA_W - 1));
        if (y < 0)
            return 10'd0;
        if (y > 479)
            return 10'd479;
        return 10'(y);
    endfunction

    logic [CW-1:0]            decim_cnt;
    logic                     strobe;
    logic signed [DATA_W-1:0] sample_val;
    logic signed [DATA_W-1:0] prev;
    logic                     trig_hit;
    logic                     vsyn_d;
    logic                     vsyn_fall;
    logic [FW-1:0]            frame_cnt;
    logic [AW-1:0]            scroll;
    logic [AW-1:0]            wr_idx;
    logic [AW-1:0]            wr_addr;
    logic                     wr_en;
    logic                     front;
    logic [AW-1:0]            rd_idx;
    logic signed [DATA_W-1:0] rd_data_p1;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] mem [0:2*DEPTH-1];

    assign strobe    = (decim_cnt == CW'(DECIM - 1));
    assign vsyn_fall = vsyn_d & ~Vsyn;

    // Channel selection for the value that would be stored at this strobe.
    always_comb begin
        sample_val = ifft_Iout;
        case (ch_sel)
            2'd1:    sample_val = ifft_Qout;
            2'd2:    sample_val = sat_mag(ifft_Iout, ifft_Qout);
            default: sample_val = ifft_Iout;
        endcase
    end

    // Level-crossing detection against the previous strobed value.
    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = (prev < trig_level) && (sample_val >= trig_level);
            default: trig_hit = (prev > trig_level) && (sample_val <= trig_level);
        endcase
    end

    // Write port: trigger sample goes to index 0, the rest follow one per strobe.
    always_comb begin
        wr_addr = wr_idx;
        wr_en   = 1'b0;
        if (KEY && strobe) begin
            if (state == S_WAIT && run && trig_hit) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == S_CAPT) begin
                wr_en = 1'b1;
            end
        end
    end

    // Free-running decimator; the strobe is the last count of each period.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY)
            decim_cnt <= '0;
        else if (strobe)
            decim_cnt <= '0;
        else
            decim_cnt <= decim_cnt + 1'b1;
    end

    // Previous strobed value for the trigger comparison.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY)
            prev <= '0;
        else if (strobe)
            prev <= sample_val;
    end

    // Vsyn edge detector and frame-paced scroll offset.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            vsyn_d    <= 1'b0;
            frame_cnt <= '0;
            scroll    <= '0;
        end else begin
            vsyn_d <= Vsyn;
            if (vsyn_fall) begin
                if (frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
                    frame_cnt <= '0;
                    scroll    <= scroll + AW'(SCROLL_STEP);
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Capture FSM and front/back bank ownership.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            state      <= S_IDLE;
            wr_idx     <= '0;
            front      <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (strobe && trig_hit) begin
                        wr_idx <= AW'(1);
                        state  <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (strobe) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == AW'(DEPTH - 1))
                            state <= S_DONE;
                    end
                end
                default: begin
                    if (vsyn_fall) begin
                        front      <= ~front;
                        swap_pulse <= 1'b1;
                        state      <= run ? S_WAIT : S_IDLE;
                    end
                end
            endcase
        end
    end

    // Sample RAM: two banks addressed by {bank, index}; writes only hit the back bank.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem[{~front, wr_addr}] <= sample_val;
    end

    // Read pointer: restarts at the scroll offset during blanking, steps per pixel.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY)
            rd_idx <= '0;
        else if (!blank_n)
            rd_idx <= scroll;
        else if (pix_en)
            rd_idx <= rd_idx + AW'(PIX_STEP);
    end

    // ---- stage p1: front-bank RAM read ----
    always_ff @(posedge CLOCK_50) begin
        if (pix_en && blank_n)
            rd_data_p1 <= mem[{front, rd_idx}];
    end

    // Valid flag for the read stage.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= pix_en & blank_n;
    end

    // ---- stage p2: Y coordinate register ----
    always_ff @(posedge CLOCK_50) begin
        if (!KEY)
            Val_CY <= 10'(Y_CENTER);
        else if (vld_p1)
            Val_CY <= y_of(rd_data_p1);
    end

endmodule

// File: tb/tb_scope_capture_ng.sv
// tb_scope_capture_ng: randomized and directed stimulus against a behavioural
// model of the scope capture block (sample queues, bank arrays, plain arithmetic).
module tb_scope_capture_ng;

    localparam int DATA_W = 8;
    localparam int DEPTH = 64;
    localparam int DECIM = 31;
    localparam int Y_CENTER = 239;
    localparam int Y_SCALE = 120;
    localparam int PIX_STEP = 1;
    localparam int SCROLL_STEP = 1;
    localparam int FPS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     KEY;
    logic                     pix_en;
    logic                     Vsyn;
    logic                     blank_n;
    logic signed [DATA_W-1:0] I;
    logic signed [DATA_W-1:0] Q;
    logic [1:0]               ch_sel;
    logic [1:0]               trig_mode;
    logic signed [DATA_W-1:0] trig_level;
    logic                     run;
    logic [9:0]               Val_CY;
    logic [1:0]               state;
    logic                     swap_pulse;

    scope_capture_ng #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM(DECIM), .Y_CENTER(Y_CENTER),
        .Y_SCALE(Y_SCALE), .PIX_STEP(PIX_STEP), .SCROLL_STEP(SCROLL_STEP),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .CLOCK_50(clk), .KEY(KEY), .pix_en(pix_en), .Vsyn(Vsyn), .blank_n(blank_n),
        .ifft_Iout(I), .ifft_Qout(Q), .ch_sel(ch_sel), .trig_mode(trig_mode),
        .trig_level(trig_level), .run(run), .Val_CY(Val_CY), .state(state),
        .swap_pulse(swap_pulse)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules for channel value and screen Y.
    function automatic int chan_f(input int ch, input int i, input int q);
        int a;
        if (ch == 1) return q;
        if (ch == 2) begin
            a = (i < 0 ? -i : i) + (q < 0 ? -q : q);
            return (a > (1 << (DATA_W-1)) - 1) ? (1 << (DATA_W-1)) - 1 : a;
        end
        return i;
    endfunction

    function automatic int y_f(input int s);
        int y;
        y = Y_CENTER - ((s * Y_SCALE) >>> (DATA_W-1));
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        return y;
    endfunction

    // ---------------- behavioural model ----------------
    int  m_state, m_y, m_cyc, m_scroll, m_fcnt, m_rd, m_prev, m_front;
    bit  m_swap, m_y_known, m_vprev;
    int  bank_v [2][DEPTH];
    bit  bank_k [2][DEPTH];
    int  cap_q[$];
    bit  pend_v, pend_k;
    int  pend_val;
    bit  ms, mf, mt;
    int  mv, ml;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < DEPTH; j++) begin
                bank_v[b][j] = 0;
                bank_k[b][j] = 1'b0;
            end
        m_y_known = 1'b0;
        m_state = 0;
        m_swap = 1'b0;
        forever begin
            @(posedge clk);
            if (!KEY) begin
                if (m_state == 2)
                    for (int j = 0; j < DEPTH; j++) bank_k[1-m_front][j] = 1'b0;
                m_state = 0; m_swap = 1'b0; m_y = Y_CENTER; m_y_known = 1'b1;
                m_cyc = 0; m_scroll = 0; m_fcnt = 0; m_rd = 0; m_prev = 0; m_front = 0;
                m_vprev = 1'b0; pend_v = 1'b0;
                cap_q.delete();
            end else begin
                ms = (m_cyc % DECIM) == DECIM - 1;
                mf = m_vprev && !Vsyn;
                mv = chan_f(int'(ch_sel), int'(I), int'(Q));
                ml = int'(trig_level);
                m_cyc++;
                m_vprev = Vsyn;
                if (pend_v) begin
                    m_y_known = pend_k;
                    m_y = y_f(pend_val);
                end
                pend_v = pix_en && blank_n;
                if (pend_v) begin
                    pend_val = bank_v[m_front][m_rd];
                    pend_k = bank_k[m_front][m_rd];
                end
                if (!blank_n) m_rd = m_scroll;
                else if (pix_en) m_rd = (m_rd + PIX_STEP) % DEPTH;
                if (mf) begin
                    m_fcnt++;
                    if (m_fcnt == FPS) begin
                        m_fcnt = 0;
                        m_scroll = (m_scroll + SCROLL_STEP) % DEPTH;
                    end
                end
                if (trig_mode == 2'd0) mt = 1'b1;
                else if (trig_mode == 2'd1) mt = (m_prev < ml) && (mv >= ml);
                else mt = (m_prev > ml) && (mv <= ml);
                m_swap = 1'b0;
                case (m_state)
                    0: if (run) m_state = 1;
                    1: if (!run) m_state = 0;
                       else if (ms && mt) begin
                           cap_q = {mv};
                           m_state = 2;
                       end
                    2: if (ms) begin
                           cap_q.push_back(mv);
                           if (cap_q.size() == DEPTH) begin
                               for (int j = 0; j < DEPTH; j++) begin
                                   bank_v[1-m_front][j] = cap_q[j];
                                   bank_k[1-m_front][j] = 1'b1;
                               end
                               m_state = 3;
                           end
                       end
                    default: if (mf) begin
                           m_front = 1 - m_front;
                           m_swap = 1'b1;
                           m_state = run ? 1 : 0;
                       end
                endcase
                if (ms) m_prev = mv;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("state", int'(state), m_state);
            chk("swap_pulse", int'(swap_pulse), int'(m_swap));
            if (m_y_known) chk("val_cy", int'(Val_CY), m_y);
        end
    end

    // ---------------- VGA timing: 4-cycle vsync, 2 lines of 6 blank + 32 active ----------------
    initial begin
        Vsyn = 1'b1; blank_n = 1'b0; pix_en = 1'b0;
        forever begin
            @(negedge clk); Vsyn = 1'b0; blank_n = 1'b0; pix_en = 1'b0;
            repeat (3) @(negedge clk);
            Vsyn = 1'b1;
            for (int l = 0; l < 2; l++) begin
                for (int b = 0; b < 6; b++) begin
                    @(negedge clk); blank_n = 1'b0; pix_en = 1'b0;
                end
                for (int p = 0; p < 32; p++) begin
                    @(negedge clk); blank_n = 1'b1; pix_en = (p % 2 == 0);
                end
            end
        end
    end

    // ---------------- sample source: 0=hold, 1=ramp per sample period, 2=random ----------------
    int data_mode = 0;
    logic signed [DATA_W-1:0] hold_i = '0;
    logic signed [DATA_W-1:0] hold_q = '0;
    initial begin
        int tick;
        tick = 0;
        I = '0; Q = '0;
        forever begin
            @(negedge clk);
            if (data_mode == 1) begin
                I = DATA_W'(tick / DECIM);
                Q = '0;
                tick++;
            end else if (data_mode == 2) begin
                I = DATA_W'($urandom);
                Q = DATA_W'($urandom);
            end else begin
                I = hold_i;
                Q = hold_q;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_state(input int s, input int budget, input string tag);
        int k;
        k = 0;
        while (int'(state) != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (int'(state) != s) begin
            n_fail++;
            $display("FAIL %s: state %0d after %0d cycles, required %0d", tag, state, k, s);
        end
    endtask

    task automatic wait_swap(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!swap_pulse && k < budget);
        n_tests++;
        if (!swap_pulse) begin
            n_fail++;
            $display("FAIL %s: swap_pulse 0 after %0d cycles, required 1", tag, k);
        end
    endtask

    task automatic capture_once(input string tag);
        run = 1'b1;
        wait_state(2, 4000, {tag, "_arm"});
        run = 1'b0;
        wait_swap(4000, {tag, "_swap"});
        chk({tag, "_idle_after_swap"}, int'(state), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        KEY = 1'b0; run = 1'b0; trig_mode = 2'd0; ch_sel = 2'd0; trig_level = '0;

        // model rule pins
        chk("model_mag_neg_full", chan_f(2, -128, -128), 127);
        chk("model_mag_q64", chan_f(2, 0, -64), 64);
        chk("model_y_pos_full", y_f(127), 120);
        chk("model_y_neg_full", y_f(-128), 359);
        chk("model_y_zero", y_f(0), 239);
        chk("model_y_mag64", y_f(64), 179);

        @(posedge clk); #3;
        chk("reset_val_cy", int'(Val_CY), 239);
        chk("reset_state", int'(state), 0);
        chk("reset_swap", int'(swap_pulse), 0);
        repeat (2) @(negedge clk);
        KEY = 1'b1;

        // free-run ramp capture; run dropped mid-capture
        data_mode = 1;
        capture_once("ramp");
        repeat (200) @(negedge clk);

        // rising trigger at level 10: 5 -> 20 fires, later 20 -> 30 does not
        data_mode = 0; hold_i = 8'sd5; hold_q = '0;
        ch_sel = 2'd0; trig_mode = 2'd1; trig_level = 8'sd10;
        run = 1'b1;
        repeat (3 * DECIM) @(negedge clk);
        chk("trig_waiting", int'(state), 1);
        hold_i = 8'sd20;
        wait_state(2, 3 * DECIM, "trig_fire");
        run = 1'b0;
        wait_swap(4000, "trig_swap");
        chk("trig_idle", int'(state), 0);
        repeat (200) @(negedge clk);
        chk("trig_display_20", int'(Val_CY), 221);
        run = 1'b1;
        repeat (3 * DECIM) @(negedge clk);
        hold_i = 8'sd30;
        repeat (4 * DECIM) @(negedge clk);
        chk("no_trig_20_to_30", int'(state), 1);
        run = 1'b0;
        repeat (2) @(negedge clk);

        // magnitude channel
        trig_mode = 2'd0; ch_sel = 2'd2;
        hold_i = DATA_W'(-128); hold_q = DATA_W'(-128);
        capture_once("mag_full");
        repeat (200) @(negedge clk);
        chk("mag_full_val_cy", int'(Val_CY), 120);
        hold_i = '0; hold_q = DATA_W'(-64);
        capture_once("mag_64");
        repeat (200) @(negedge clk);
        chk("mag_64_val_cy", int'(Val_CY), 179);

        // random rounds with back-to-back re-arming
        data_mode = 2;
        for (int r = 0; r < 4; r++) begin
            ch_sel = 2'($urandom_range(0, 3));
            trig_mode = (ch_sel == 2'd2) ? 2'd0 : 2'($urandom_range(0, 3));
            trig_level = DATA_W'($urandom_range(0, 60) - 30);
            run = 1'b1;
            wait_swap(6000, "rand_swap_a");
            wait_swap(6000, "rand_swap_b");
            run = 1'b0;
            wait_state(0, 6000, "rand_idle");
        end

        // scroll over 128 frames with random front bank contents
        ch_sel = 2'd0; trig_mode = 2'd0;
        capture_once("scroll_fill");
        repeat (128 * 80) @(negedge clk);

        // reset during capture while bank 0 is displayed
        if (m_front != 0) capture_once("align_front");
        run = 1'b1;
        wait_state(2, 4000, "rst_arm");
        repeat (100) @(negedge clk);
        KEY = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", int'(state), 0);
        chk("rst_mid_val_cy", int'(Val_CY), 239);
        KEY = 1'b1;
        run = 1'b1;
        repeat (1000) @(negedge clk);
        run = 1'b0;
        wait_state(0, 5000, "final_idle");
        repeat (200) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scope_capture_ng.md
# scope_capture_ng

Parametrised trace-capture and display block for the OFDM VGA oscilloscope. It decimates the IFFT I/Q output stream and captures one selected channel (I, Q or |I|+|Q|) into a ping-pong buffer, gated by an optional level trigger. It then streams the stable bank to the VGA pixel pipeline as a scaled, clamped Y coordinate, with frame-paced horizontal scrolling. Banks swap only at vertical sync, so the display never tears.

## Interface
- DATA_W, 8: width of ifft_Iout/ifft_Qout and of stored samples (signed)
- DEPTH, 64: samples per bank; power of two, ≥4
- DECIM, 31: input clocks per captured sample; ≥1
- Y_CENTER, 239: Val_CY for a zero sample
- Y_SCALE, 120: pixels for full-scale (2^(DATA_W-1)) deflection
- PIX_STEP, 1: buffer index increment per active pixel
- SCROLL_STEP, 1: scroll offset increment per scroll event
- FRAMES_PER_STEP, 2: Vsyn falling edges per scroll event; ≥1
- CLOCK_50  in  1  sole clock; all logic on rising edge
- KEY  in  1  reset, synchronous, active-low
- pix_en  in  1  one-cycle VGA pixel strobe (replaces separate VGA_clk)
- Vsyn  in  1  VGA vertical sync, CLOCK_50-synchronous
- blank_n  in  1  high during active video
- ifft_Iout  in  DATA_W  signed I sample, valid every cycle
- ifft_Qout  in  DATA_W  signed Q sample, valid every cycle
- ch_sel  in  2  0=I, 1=Q, 2=|I|+|Q|, 3=I
- trig_mode  in  2  0=free-run, 1=rising-level trigger, 2/3=falling-level trigger
- trig_level  in  DATA_W  signed trigger threshold
- run  in  1  1=keep re-arming; 0=finish current capture, then idle
- Val_CY  out  10  Y coordinate for current pixel
- state  out  2  0=IDLE, 1=WAIT_TRIG, 2=CAPTURE, 3=DONE
- swap_pulse  out  1  one-cycle pulse when the displayed bank changes

## Operation
- Decimator: counter 0..DECIM-1, wraps. Sample strobe fires in the cycle the counter equals DECIM-1. Counter runs free in every state.
- Channel value at strobe:
  - I or Q taken directly.
  - Magnitude = |I|+|Q| computed at DATA_W+1 bits, saturated to 2^(DATA_W-1)-1.
  - |−2^(DATA_W-1)| is treated as 2^(DATA_W-1) before saturation.
  - ch_sel is sampled per strobe; the stored value is the processed value.
- Trigger, evaluated on strobes only. prev = previous strobed value; prev resets to 0.
  - Rising: prev < trig_level and cur ≥ trig_level.
  - Falling: prev > trig_level and cur ≤ trig_level.
- FSM:
  - IDLE → WAIT_TRIG when run=1.
  - WAIT_TRIG → CAPTURE on a trigger strobe, or on any strobe when trig_mode=0. That triggering sample is written to back-bank index 0.
  - CAPTURE: writes one sample per strobe at indices 1..DEPTH-1. After index DEPTH-1 is written → DONE.
  - DONE: on the first Vsyn falling edge (Vsyn registered, edge = prev 1 & cur 0), front/back banks toggle and swap_pulse asserts that cycle. Next state is WAIT_TRIG if run=1, else IDLE.
  - run=0 during WAIT_TRIG → IDLE; during CAPTURE it is ignored.
- Scroll: count Vsyn falling edges. Every FRAMES_PER_STEP edges, scroll = (scroll + SCROLL_STEP) mod DEPTH.
- Readout:
  - While blank_n=0, rd_idx ← scroll.
  - On pix_en with blank_n=1, rd_idx ← (rd_idx + PIX_STEP) mod DEPTH. The sample at the pre-increment rd_idx in the front bank is the one displayed.
- Y arithmetic (signed s, 32-bit intermediate):
  - y = Y_CENTER − ((s·Y_SCALE) >>> (DATA_W-1)), arithmetic shift.
  - Clamp to 0..479.
  - DATA_W=8, Y_SCALE=120: s=127→120, s=−128→359, s=0→239.

## Timing
- Reset (KEY=0 at a clock edge) sets:
  - Val_CY=Y_CENTER, state=IDLE, swap_pulse=0.
  - Decimator=0, scroll=0, frame count=0, rd_idx=0, prev=0, front bank=0.
  - RAM contents are not cleared.
- Reset mid-capture abandons the capture; the front bank is unchanged.
- Val_CY latency: sample selected at pix_en cycle t appears at cycle t+2 (RAM read + Y register). It holds until the next update; Val_CY is not updated while blank_n=0.
- Swap and a pixel read in the same cycle: that read uses the old front bank.
- Vsyn edge in the cycle CAPTURE→DONE does not swap; the next edge does.
- Simultaneous scroll event and swap: both take effect.
- Strobe in the same cycle as IDLE→WAIT_TRIG is not evaluated for trigger.
- Writes never target the front bank.

## Test plan
- Free-run, DECIM=31, I ramp 0,1,2…: after DONE and a Vsyn fall, swap_pulse=1 for 1 cycle. The first active line reads samples spaced 1 apart; Val_CY for sample 0 is 239 at t+2.
- trig_mode=1, level=10, I steps 5→20: capture starts at the 20 sample (index 0=20). It does not start on a step 20→30.
- ch_sel=2, I=−128, Q=−128: stored 127, Val_CY=120. With I=0, Q=−64: stored 64, Val_CY=179.
- FRAMES_PER_STEP=2, SCROLL_STEP=1, DEPTH=64: after 128 Vsyn falls, scroll wraps back to 0. The first pixel of each line shows index scroll.
- run dropped during CAPTURE: capture completes, swaps at next Vsyn fall, then state=IDLE.
- KEY=0 during CAPTURE: next cycle state=IDLE, Val_CY=239; the previously displayed bank is still read correctly after re-arm.
